// File: rtl/memory_responder.sv
// Byte-addressed memory responder with a fixed-latency request/complete
// handshake (memEn / mfc), big-endian byte ordering and wrap-around indexing.
module memory_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        memEn,
  input  logic        memRW,
  input  logic [1:0]  wordSel,
  input  logic [31:0] address,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        mfc,
  output logic        memErr
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] SEL_BYTE = 2'b00;
  localparam logic [1:0] SEL_HALF = 2'b01;
  localparam logic [1:0] SEL_WORD = 2'b10;
  localparam logic [1:0] SEL_RSVD = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t state, next_state;

  logic [3:0]    cnt;
  logic          cap_rw;
  logic [1:0]    cap_sel;
  logic [AW-1:0] cap_addr;
  logic [31:0]   cap_data;

  logic capture, done_entry, leave_done;
  logic reserved, mem_we;

  logic [AW-1:0] eff, a0, a1, a2, a3;
  logic [31:0]   rd_data;

  logic [7:0] mem [DEPTH];

  // Only the low index bits of the address select a byte; the rest wrap away.
  logic unused_addr;
  assign unused_addr = ^address[31:AW];

  // State register; clr returns to IDLE without waiting for a clock.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode plus the one-cycle strobes that drive the datapath.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    done_entry = 1'b0;
    leave_done = 1'b0;
    case (state)
      IDLE: begin
        if (memEn) begin
          next_state = WAIT;
          capture    = 1'b1;
        end
      end
      WAIT: begin
        if (!memEn) begin
          next_state = IDLE;
        end else if (cnt == 4'd0) begin
          next_state = DONE;
          done_entry = 1'b1;
        end
      end
      DONE: begin
        if (!memEn) begin
          next_state = IDLE;
          leave_done = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign reserved = (cap_sel == SEL_RSVD);
  assign mem_we   = done_entry && !cap_rw && !reserved;

  // Request capture and wait counter; later input changes never reach the access.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt      <= 4'd0;
      cap_rw   <= 1'b0;
      cap_sel  <= 2'b00;
      cap_addr <= '0;
      cap_data <= 32'd0;
    end else if (capture) begin
      cnt      <= 4'(LATENCY - 1);
      cap_rw   <= memRW;
      cap_sel  <= wordSel;
      cap_addr <= address[AW-1:0];
      cap_data <= dataIn;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Size-aligned base index and the consecutive bytes it covers (big-endian).
  always_comb begin
    eff = cap_addr;
    if (cap_sel == SEL_HALF) eff = {cap_addr[AW-1:1], 1'b0};
    if (cap_sel == SEL_WORD) eff = {cap_addr[AW-1:2], 2'b00};
    a0 = eff;
    a1 = eff + AW'(1);
    a2 = eff + AW'(2);
    a3 = eff + AW'(3);
  end

  // Zero-extended read data assembled MSB-first from the addressed bytes.
  always_comb begin
    rd_data = 32'd0;
    case (cap_sel)
      SEL_BYTE: rd_data = {24'd0, mem[a0]};
      SEL_HALF: rd_data = {16'd0, mem[a0], mem[a1]};
      SEL_WORD: rd_data = {mem[a0], mem[a1], mem[a2], mem[a3]};
      default:  rd_data = 32'd0;
    endcase
  end

  // Completion outputs: set on the DONE-entry edge, cleared when the request drops.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mfc     <= 1'b0;
      memErr  <= 1'b0;
      dataOut <= 32'd0;
    end else if (done_entry) begin
      mfc    <= 1'b1;
      memErr <= reserved;
      if (reserved)    dataOut <= 32'd0;
      else if (cap_rw) dataOut <= rd_data;
    end else if (leave_done) begin
      mfc    <= 1'b0;
      memErr <= 1'b0;
    end
  end

  // Byte array storage; it has no reset so contents survive clr.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      case (cap_sel)
        SEL_BYTE: mem[a0] <= cap_data[7:0];
        SEL_HALF: begin
          mem[a0] <= cap_data[15:8];
          mem[a1] <= cap_data[7:0];
        end
        default: begin
          mem[a0] <= cap_data[31:24];
          mem[a1] <= cap_data[23:16];
          mem[a2] <= cap_data[15:8];
          mem[a3] <= cap_data[7:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder: randomized accesses compared
// against a byte-array model, plus directed abort, reserved and reset cases.
module tb_memory_responder;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;
  localparam int MAXWAIT = 20;

  logic        clk = 1'b0;
  logic        clr;
  logic        memEn;
  logic        memRW;
  logic [1:0]  wordSel;
  logic [31:0] address;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        mfc;
  logic        memErr;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [DEPTH];

  memory_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .clr(clr), .memEn(memEn), .memRW(memRW), .wordSel(wordSel),
    .address(address), .dataIn(dataIn), .dataOut(dataOut), .mfc(mfc),
    .memErr(memErr)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Reference read: aligned base modulo DEPTH, bytes concatenated MSB first.
  function automatic logic [31:0] model_read(input logic [1:0] sel, input logic [31:0] addr);
    int base;
    int n;
    logic [31:0] v;
    if (sel == 2'b11) return 32'h0;
    n = (sel == 2'b00) ? 1 : (sel == 2'b01) ? 2 : 4;
    base = int'(addr % DEPTH);
    base = base - (base % n);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[(base + i) % DEPTH]);
    return v;
  endfunction

  // Reference write: low-order n bytes of data stored MSB first.
  task automatic model_write(input logic [1:0] sel, input logic [31:0] addr, input logic [31:0] data);
    int base;
    int n;
    if (sel == 2'b11) return;
    n = (sel == 2'b00) ? 1 : (sel == 2'b01) ? 2 : 4;
    base = int'(addr % DEPTH);
    base = base - (base % n);
    for (int i = 0; i < n; i++) ref_mem[(base + i) % DEPTH] = 8'(data >> (8 * (n - 1 - i)));
  endtask

  // Runs one full handshake from IDLE; scrambles inputs while waiting.
  task automatic do_access(input logic rw, input logic [1:0] sel, input logic [31:0] addr,
                           input logic [31:0] data, output logic [31:0] rd, output logic err,
                           output int lat, output logic mfc_after, output logic err_after);
    memRW = rw; wordSel = sel; address = addr; dataIn = data; memEn = 1'b1;
    @(posedge clk); #1;
    memRW = ~rw; wordSel = 2'($urandom); address = $urandom; dataIn = $urandom;
    lat = 0;
    while (mfc !== 1'b1 && lat < MAXWAIT) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = dataOut;
    err = memErr;
    memEn = 1'b0;
    @(posedge clk); #1;
    mfc_after = mfc;
    err_after = memErr;
  endtask

  task automatic test_reset;
    clr = 1'b0; memEn = 1'b0; memRW = 1'b0; wordSel = 2'b00; address = 32'h0; dataIn = 32'h0;
    #2 clr = 1'b1;
    #10;
    checks++; if (mfc !== 1'b0) begin errors++; $display("[TB] FAIL reset_mfc got %b want 0", mfc); end
    checks++; if (memErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_memErr got %b want 0", memErr); end
    checks++; if (dataOut !== 32'h0) begin errors++; $display("[TB] FAIL reset_dataOut got %h want 0", dataOut); end
    @(negedge clk) clr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fill;
    logic [31:0] rd, w;
    logic err, ma, ea;
    int lat;
    for (int a = 0; a < DEPTH; a += 4) begin
      w = $urandom;
      do_access(1'b0, 2'b10, 32'(a), w, rd, err, lat, ma, ea);
      model_write(2'b10, 32'(a), w);
      checks++;
      if (lat !== LATENCY || err !== 1'b0 || ma !== 1'b0) begin
        errors++;
        $display("[TB] FAIL fill_write addr %0h got lat=%0d err=%b mfc_after=%b want lat=%0d err=0 mfc_after=0",
                 a, lat, err, ma, LATENCY);
      end
    end
  endtask

  task automatic test_directed;
    logic [31:0] rd;
    logic err, ma, ea;
    int lat;
    do_access(1'b0, 2'b10, 32'h10, 32'hDEADBEEF, rd, err, lat, ma, ea);
    model_write(2'b10, 32'h10, 32'hDEADBEEF);
    do_access(1'b1, 2'b10, 32'h10, 32'h0, rd, err, lat, ma, ea);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL word_read got %h want deadbeef", rd); end
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL word_latency got %0d want 2", lat); end
    do_access(1'b1, 2'b00, 32'h11, 32'h0, rd, err, lat, ma, ea);
    checks++; if (rd !== 32'h000000AD) begin errors++; $display("[TB] FAIL byte_read got %h want 000000ad", rd); end
    do_access(1'b1, 2'b01, 32'h13, 32'h0, rd, err, lat, ma, ea);
    checks++; if (rd !== 32'h0000BEEF || err !== 1'b0) begin errors++; $display("[TB] FAIL half_masked got %h err=%b want 0000beef err=0", rd, err); end
    do_access(1'b0, 2'b00, 32'h12, 32'hFFFFFF55, rd, err, lat, ma, ea);
    model_write(2'b00, 32'h12, 32'hFFFFFF55);
    do_access(1'b1, 2'b10, 32'h10, 32'h0, rd, err, lat, ma, ea);
    checks++; if (rd !== 32'hDEAD55EF) begin errors++; $display("[TB] FAIL byte_merge got %h want dead55ef", rd); end
    do_access(1'b0, 2'b10, 32'h100, 32'h01020304, rd, err, lat, ma, ea);
    model_write(2'b10, 32'h100, 32'h01020304);
    do_access(1'b1, 2'b10, 32'h000, 32'h0, rd, err, lat, ma, ea);
    checks++; if (rd !== 32'h01020304) begin errors++; $display("[TB] FAIL wrap_read got %h want 01020304", rd); end
  endtask

  task automatic test_abort;
    logic [31:0] rd;
    logic err, ma, ea, saw;
    int lat;
    do_access(1'b0, 2'b10, 32'h20, 32'h12345678, rd, err, lat, ma, ea);
    model_write(2'b10, 32'h20, 32'h12345678);
    for (int k = 0; k < LATENCY; k++) begin
      memRW = 1'b0; wordSel = 2'b10; address = 32'h20; dataIn = 32'hFFFFFFFF; memEn = 1'b1;
      @(posedge clk); #1;
      repeat (k) begin @(posedge clk); #1; end
      memEn = 1'b0;
      saw = 1'b0;
      repeat (LATENCY + 3) begin
        @(posedge clk); #1;
        if (mfc !== 1'b0) saw = 1'b1;
      end
      checks++; if (saw !== 1'b0) begin errors++; $display("[TB] FAIL abort_mfc stage %0d got mfc seen=%b want 0", k, saw); end
    end
    do_access(1'b1, 2'b10, 32'h20, 32'h0, rd, err, lat, ma, ea);
    checks++; if (rd !== model_read(2'b10, 32'h20)) begin errors++; $display("[TB] FAIL abort_contents got %h want %h", rd, model_read(2'b10, 32'h20)); end
  endtask

  task automatic test_reserved;
    logic [31:0] rd;
    logic err, ma, ea;
    int lat;
    do_access(1'b1, 2'b11, 32'h40, 32'h0, rd, err, lat, ma, ea);
    checks++; if (lat !== LATENCY) begin errors++; $display("[TB] FAIL rsvd_mfc got lat=%0d want %0d", lat, LATENCY); end
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin errors++; $display("[TB] FAIL rsvd_result got err=%b data=%h want err=1 data=0", err, rd); end
    checks++; if (ma !== 1'b0 || ea !== 1'b0) begin errors++; $display("[TB] FAIL rsvd_clear got mfc=%b err=%b want 0 0", ma, ea); end
    do_access(1'b0, 2'b11, 32'h44, 32'hA5A5A5A5, rd, err, lat, ma, ea);
    do_access(1'b1, 2'b10, 32'h44, 32'h0, rd, err, lat, ma, ea);
    checks++; if (rd !== model_read(2'b10, 32'h44)) begin errors++; $display("[TB] FAIL rsvd_nowrite got %h want %h", rd, model_read(2'b10, 32'h44)); end
  endtask

  task automatic test_hold;
    logic [31:0] exp;
    int lat;
    exp = model_read(2'b10, 32'h10);
    memRW = 1'b1; wordSel = 2'b10; address = 32'h10; dataIn = 32'h0; memEn = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (mfc !== 1'b1 && lat < MAXWAIT) begin @(posedge clk); #1; lat++; end
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if (mfc !== 1'b1 || dataOut !== exp) begin errors++; $display("[TB] FAIL hold got mfc=%b data=%h want 1 %h", mfc, dataOut, exp); end
    end
    memEn = 1'b0;
    @(posedge clk); #1;
    checks++; if (mfc !== 1'b0 || dataOut !== exp) begin errors++; $display("[TB] FAIL retain got mfc=%b data=%h want 0 %h", mfc, dataOut, exp); end
  endtask

  task automatic test_reset_mid_access;
    logic [31:0] rd;
    logic err, ma, ea;
    int lat;
    for (int sel = 0; sel < 2; sel++) begin
      memRW = (sel == 0); wordSel = (sel == 0) ? 2'b10 : 2'b11; address = 32'h10; dataIn = 32'h0; memEn = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      while (mfc !== 1'b1 && lat < MAXWAIT) begin @(posedge clk); #1; lat++; end
      #2 clr = 1'b1;
      #1;
      checks++;
      if (mfc !== 1'b0 || memErr !== 1'b0 || dataOut !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_done got mfc=%b err=%b data=%h want 0 0 0", mfc, memErr, dataOut);
      end
      memEn = 1'b0;
      #1 clr = 1'b0;
      @(posedge clk); #1;
    end
    for (int k = 0; k < LATENCY; k++) begin
      memRW = 1'b0; wordSel = 2'b10; address = 32'h30; dataIn = 32'hCAFEF00D; memEn = 1'b1;
      @(posedge clk); #1;
      repeat (k) begin @(posedge clk); #1; end
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0; memEn = 1'b0;
      @(posedge clk); #1;
      checks++; if (mfc !== 1'b0) begin errors++; $display("[TB] FAIL reset_wait_mfc stage %0d got %b want 0", k, mfc); end
    end
    do_access(1'b1, 2'b10, 32'h10, 32'h0, rd, err, lat, ma, ea);
    checks++; if (rd !== model_read(2'b10, 32'h10)) begin errors++; $display("[TB] FAIL reset_preserve got %h want %h", rd, model_read(2'b10, 32'h10)); end
    do_access(1'b1, 2'b10, 32'h30, 32'h0, rd, err, lat, ma, ea);
    checks++; if (rd !== model_read(2'b10, 32'h30)) begin errors++; $display("[TB] FAIL reset_nowrite got %h want %h", rd, model_read(2'b10, 32'h30)); end
  endtask

  task automatic test_random;
    logic [31:0] rd, addr, data, exp_d;
    logic [1:0] sel;
    logic rw, err, ma, ea, exp_e;
    int lat, r;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 11);
      sel = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 11) ? 2'b10 : 2'b11;
      rw = 1'($urandom);
      addr = $urandom;
      data = $urandom;
      exp_e = (sel == 2'b11);
      exp_d = model_read(sel, addr);
      do_access(rw, sel, addr, data, rd, err, lat, ma, ea);
      if (!rw) model_write(sel, addr, data);
      checks++; if (lat !== LATENCY) begin errors++; $display("[TB] FAIL rand_latency #%0d got %0d want %0d", i, lat, LATENCY); end
      checks++; if (err !== exp_e) begin errors++; $display("[TB] FAIL rand_err #%0d got %b want %b", i, err, exp_e); end
      if (rw || exp_e) begin
        checks++; if (rd !== exp_d) begin errors++; $display("[TB] FAIL rand_data #%0d sel=%b addr=%h got %h want %h", i, sel, addr, rd, exp_d); end
      end
      checks++; if (ma !== 1'b0 || ea !== 1'b0) begin errors++; $display("[TB] FAIL rand_clear #%0d got mfc=%b err=%b want 0 0", i, ma, ea); end
    end
  endtask

  // Watchdog so the run always ends even if a wait loop misbehaves.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Scenario sequence.
  initial begin
    test_reset();
    test_fill();
    test_directed();
    test_abort();
    test_reserved();
    test_hold();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
